// File: rtl/recip_seq_pkg.sv
// Shared types and helpers for the sequential reciprocal unit: FSM encoding,
// counter sizing and an integer reference model of floor(2^FRAC_W/(a+1)).
package recip_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_CALC = 2'd1,
    RS_DONE = 2'd2
  } recip_state_t;

  function automatic int recip_cnt_w(input int frac_w);
    return $clog2(frac_w + 1);
  endfunction

  // a = 0 is exactly 1.0, which does not fit in Q0.frac_w, so it saturates.
  function automatic logic [31:0] recip_ref(input int a, input int frac_w);
    logic [31:0] v_one;
    v_one = 32'd1 << frac_w;
    if (a == 0) return v_one - 32'd1;
    return v_one / 32'(a + 1);
  endfunction

endpackage

// File: rtl/recip_seq_if.sv
// Request/result handshake bundle for recip_seq; the unit sits on the slave side.
interface recip_seq_if #(
  parameter int IN_W   = 4,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_a;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [FRAC_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output in_valid, in_a, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/recip_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract d if it fits.
// The shifted remainder is IN_W+2 bits; its top bit alone already implies r' > d.
module recip_div_step #(
  parameter int IN_W = 4
) (
  input  logic [IN_W:0] i_r,
  input  logic          i_bit,
  input  logic [IN_W:0] i_d,
  output logic [IN_W:0] o_r_next,
  output logic          o_q_bit
);
  logic [IN_W+1:0] w_rs;
  logic [IN_W:0]   w_diff;

  assign w_rs     = {i_r, i_bit};
  assign o_q_bit  = w_rs[IN_W+1] | (w_rs[IN_W:0] >= i_d);
  // The true difference is below d, so the low IN_W+1 bits hold it exactly.
  assign w_diff   = w_rs[IN_W:0] - i_d;
  assign o_r_next = o_q_bit ? w_diff : w_rs[IN_W:0];
endmodule

// File: rtl/recip_seq.sv
// Sequential reciprocal floor(2^FRAC_W/(a+1)), one request in flight, FRAC_W+1 cycle latency.
// in_ready only in IDLE; result is held stable in DONE until out_ready.
module recip_seq
  import recip_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 2
) (
  input  logic       clk,
  input  logic       rst,
  recip_seq_if.slave s
);
  localparam int CW = recip_cnt_w(FRAC_W);

  recip_state_t      r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [IN_W:0]     r_d;
  logic [IN_W:0]     r_r;
  logic [FRAC_W-1:0] r_q;
  logic [TAG_W-1:0]  r_tag;
  logic [FRAC_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_bit;
  logic              w_last;
  logic [IN_W:0]     w_r_next;
  logic              w_q_bit;
  logic [FRAC_W:0]   w_q_full;

  // Dividend is 2^FRAC_W: a single 1 on the first step, zeros afterwards.
  assign w_bit    = (r_cnt == CW'(FRAC_W));
  assign w_last   = (r_cnt == '0);
  assign w_q_full = {r_q, w_q_bit};

  recip_div_step #(.IN_W(IN_W)) u_step (
    .i_r      (r_r),
    .i_bit    (w_bit),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RS_IDLE: if (s.in_valid) w_state_nxt = RS_CALC;
      RS_CALC: if (w_last) w_state_nxt = RS_DONE;
      RS_DONE: if (s.out_ready) w_state_nxt = RS_IDLE;
      default: w_state_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_d        <= '0;
      r_r        <= '0;
      r_q        <= '0;
      r_tag      <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else begin
      if (r_state == RS_IDLE && s.in_valid) begin
        r_d   <= {1'b0, s.in_a} + (IN_W+1)'(1);
        r_tag <= s.in_tag;
        r_r   <= '0;
        r_q   <= '0;
        r_cnt <= CW'(FRAC_W);
      end else if (r_state == RS_CALC) begin
        r_r   <= w_r_next;
        r_q   <= w_q_full[FRAC_W-1:0];
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          // Quotient bit FRAC_W is set only for d = 1 (exact 1.0): saturate.
          r_out_data <= w_q_full[FRAC_W] ? {FRAC_W{1'b1}} : w_q_full[FRAC_W-1:0];
          r_out_tag  <= r_tag;
        end
      end
    end
  end

  assign s.in_ready  = (r_state == RS_IDLE);
  assign s.out_valid = (r_state == RS_DONE);
  assign s.busy      = (r_state != RS_IDLE);
  assign s.out_data  = r_out_data;
  assign s.out_tag   = r_out_tag;
endmodule

// File: tb/tb_recip_seq.sv
// Directed and streaming checks of recip_seq at (IN_W,FRAC_W) = (4,8) and (8,12).
module tb_recip_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  recip_seq_if #(.IN_W(4), .FRAC_W(8),  .TAG_W(2)) i0 ();
  recip_seq_if #(.IN_W(8), .FRAC_W(12), .TAG_W(2)) i1 ();

  recip_seq #(.IN_W(4), .FRAC_W(8),  .TAG_W(2)) u0 (.clk(clk), .rst(rst), .s(i0));
  recip_seq #(.IN_W(8), .FRAC_W(12), .TAG_W(2)) u1 (.clk(clk), .rst(rst), .s(i1));

  typedef struct {
    logic [3:0] a;
    logic [1:0] tag;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model8(input logic [3:0] a);
    if (a == 4'd0) return 8'hFF;
    return 8'((32'd256) / (32'(a) + 32'd1));
  endfunction

  // Issue one request on dut0 (must be IDLE), wait for out_valid; no consume edge.
  task automatic run0(input logic [3:0] a, input logic [1:0] tag,
                      output logic [7:0] d, output logic [1:0] t, output int lat);
    int t0;
    i0.in_a = a; i0.in_tag = tag; i0.in_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    i0.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (i0.out_valid) begin lat = cyc - t0; break; end
    end
    d = i0.out_data; t = i0.out_tag;
  endtask

  task automatic run1(input logic [7:0] a, output logic [11:0] d, output int lat);
    int t0;
    i1.in_a = a; i1.in_tag = 2'd1; i1.in_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    i1.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (i1.out_valid) begin lat = cyc - t0; break; end
    end
    d = i1.out_data;
    @(posedge clk); #1;
  endtask

  // Stream n requests through dut0; rnd randomises in_valid gaps and out_ready.
  task automatic stream(input int n, input bit rnd, input string name);
    logic [7:0] qd[$];
    logic [1:0] qt[$];
    int  sent = 0, got = 0, budget = 0, last_t = -1;
    bit  acc, hs;
    i0.in_a = 4'($urandom); i0.in_tag = 2'($urandom);
    i0.in_valid = rnd ? 1'($urandom) : 1'b1;
    i0.out_ready = 1'b1;
    while (got < n && budget < 3000) begin
      @(negedge clk);
      acc = i0.in_valid && i0.in_ready;
      hs  = i0.out_valid && i0.out_ready;
      if (hs) begin
        if (qd.size() == 0) begin
          chk({name, " spurious result"}, 32'(i0.out_data), 32'hDEAD);
        end else begin
          chk({name, " data"}, 32'(i0.out_data), 32'(qd.pop_front()));
          chk({name, " tag"},  32'(i0.out_tag),  32'(qt.pop_front()));
        end
        if (!rnd && last_t >= 0) chk({name, " interval"}, 32'(cyc - last_t), 32'd11);
        last_t = cyc;
        got++;
      end
      @(posedge clk); #1;
      budget++;
      if (acc) begin
        qd.push_back(model8(i0.in_a));
        qt.push_back(i0.in_tag);
        sent++;
        i0.in_a = 4'($urandom); i0.in_tag = 2'($urandom);
        i0.in_valid = (sent < n) && (rnd ? 1'($urandom) : 1'b1);
      end else if (rnd && sent < n) begin
        i0.in_valid = 1'($urandom);
      end
      if (rnd) i0.out_ready = 1'($urandom);
    end
    i0.in_valid = 1'b0;
    i0.out_ready = 1'b1;
    chk({name, " results received"}, 32'(got), 32'(n));
    chk({name, " requests sent"}, 32'(sent), 32'(n));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [1:0]  t;
    logic [11:0] d1;
    int          lat;

    tbl[0]  = '{4'd0,  2'd0, 8'hFF}; tbl[1]  = '{4'd1,  2'd1, 8'h80};
    tbl[2]  = '{4'd2,  2'd2, 8'h55}; tbl[3]  = '{4'd3,  2'd3, 8'h40};
    tbl[4]  = '{4'd4,  2'd0, 8'h33}; tbl[5]  = '{4'd5,  2'd1, 8'h2A};
    tbl[6]  = '{4'd6,  2'd2, 8'h24}; tbl[7]  = '{4'd7,  2'd3, 8'h20};
    tbl[8]  = '{4'd8,  2'd0, 8'h1C}; tbl[9]  = '{4'd9,  2'd1, 8'h19};
    tbl[10] = '{4'd10, 2'd2, 8'h17}; tbl[11] = '{4'd11, 2'd3, 8'h15};
    tbl[12] = '{4'd12, 2'd0, 8'h13}; tbl[13] = '{4'd13, 2'd1, 8'h12};
    tbl[14] = '{4'd14, 2'd2, 8'h11}; tbl[15] = '{4'd15, 2'd3, 8'h10};

    i0.in_valid = 1'b0; i0.in_a = '0; i0.in_tag = '0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.in_a = '0; i1.in_tag = '0; i1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready",  32'(i0.in_ready),  32'd1);
    chk("reset out_valid", 32'(i0.out_valid), 32'd0);
    chk("reset busy",      32'(i0.busy),      32'd0);
    chk("reset out_data",  32'(i0.out_data),  32'd0);
    chk("reset out_tag",   32'(i0.out_tag),   32'd0);

    for (int i = 0; i < 16; i++) begin
      run0(tbl[i].a, tbl[i].tag, d, t, lat);
      chk($sformatf("sweep a=%0d data", i),    32'(d),   32'(tbl[i].exp));
      chk($sformatf("sweep a=%0d tag", i),     32'(t),   32'(tbl[i].tag));
      chk($sformatf("sweep a=%0d latency", i), 32'(lat), 32'd9);
      @(posedge clk); #1;
    end

    // Held result under backpressure; a request during DONE must be ignored.
    i0.out_ready = 1'b0;
    run0(4'd5, 2'd2, d, t, lat);
    chk("stall first data", 32'(d), 32'h2A);
    chk("stall latency", 32'(lat), 32'd9);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin i0.in_valid = 1'b1; i0.in_a = 4'd3; i0.in_tag = 2'd1; end
      @(posedge clk); #1;
      i0.in_valid = 1'b0;
      chk("stall out_valid", 32'(i0.out_valid), 32'd1);
      chk("stall data",      32'(i0.out_data),  32'h2A);
      chk("stall tag",       32'(i0.out_tag),   32'd2);
      chk("stall in_ready",  32'(i0.in_ready),  32'd0);
    end
    i0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 32'(i0.out_valid), 32'd0);
    chk("release in_ready",  32'(i0.in_ready),  32'd1);
    chk("release busy",      32'(i0.busy),      32'd0);
    run0(4'd7, 2'd3, d, t, lat);
    chk("after stall data", 32'(d), 32'h20);
    chk("after stall tag",  32'(t), 32'd3);
    @(posedge clk); #1;

    run1(8'd0, d1, lat);
    chk("w12 a=0 data", 32'(d1), 32'hFFF);
    chk("w12 a=0 latency", 32'(lat), 32'd13);
    run1(8'd2, d1, lat);
    chk("w12 a=2 data", 32'(d1), 32'h555);
    run1(8'd255, d1, lat);
    chk("w12 a=255 data", 32'(d1), 32'h010);
    chk("w12 a=255 latency", 32'(lat), 32'd13);

    // Reset while the fourth CALC step is being taken.
    i0.in_a = 4'd9; i0.in_tag = 2'd2; i0.in_valid = 1'b1;
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-calc busy before reset", 32'(i0.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid reset in_ready",  32'(i0.in_ready),  32'd1);
    chk("mid reset busy",      32'(i0.busy),      32'd0);
    chk("mid reset out_valid", 32'(i0.out_valid), 32'd0);
    chk("mid reset out_data",  32'(i0.out_data),  32'd0);
    run0(4'd1, 2'd1, d, t, lat);
    chk("post reset data",    32'(d),   32'h80);
    chk("post reset latency", 32'(lat), 32'd9);
    @(posedge clk); #1;

    stream(6, 1'b0, "b2b");
    stream(25, 1'b1, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/recip_seq.md
# recip_seq

Parametrised sequential reciprocal generator for the fixed-point datapath. It accepts an unsigned index `a` and returns `floor(2^FRAC_W / (a+1))` as an unsigned Q0.FRAC_W fraction. The `a = 0` case (exact 1.0) saturates to all-ones. It replaces the fixed 16-entry, 8-bit reciprocal table: a restoring long divider computes any input width and precision, and results leave through a valid/ready handshake with a pass-through tag, so several channels can share one unit.

## Interface
Parameters:
- `IN_W`, 4: index width; divisor `d = a+1` spans 1..2^IN_W.
- `FRAC_W`, 8: result fraction bits; must satisfy FRAC_W >= IN_W.
- `TAG_W`, 2: channel/tag width, carried unchanged from request to result.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `in_a` in IN_W: index a.
- `in_tag` in TAG_W: request tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result.
- `out_data` out FRAC_W: reciprocal, Q0.FRAC_W.
- `out_tag` out TAG_W: tag of the request that produced `out_data`.
- `busy` out 1: a request is held (state is not IDLE).

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` at an edge: latch `d = in_a+1` (IN_W+1 bits) and `in_tag`; clear remainder `r` and quotient `q` (FRAC_W+1 bits); load step counter = FRAC_W; go to CALC.
- CALC: one restoring step per edge, MSB first, dividend `2^FRAC_W`:
  - Dividend bit is 1 on the first step and 0 on later steps.
  - `r' = {r, bit}`; if `r' >= d` then `r = r'-d` and the q bit is 1, else `r = r'` and the q bit is 0.
  - `r` needs IN_W+1 bits; the compare is done at IN_W+2 bits.
  - When the counter reaches 0 (step FRAC_W+1 completes), register the result and go to DONE.
- Result rule: if `q[FRAC_W]`=1 (only when d=1), `out_data` = all-ones; else `out_data = q[FRAC_W-1:0]`. This is truncation with no rounding.
- DONE:
  - `out_valid`=1; `out_data` and `out_tag` stay stable while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in CALC and DONE. `in_valid` in those states is ignored; the input is not captured.
- One request is in flight at a time.
- Reset (any state, including mid-CALC or DONE): state goes to IDLE. `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `out_tag`=0. The in-flight request is discarded with no partial output.

## Timing
- Request accepted at edge k → `out_valid` high from edge k+FRAC_W+1. Latency is FRAC_W+1 cycles, independent of `a`.
- Result consumed at edge m (`out_valid`&&`out_ready`) → `in_ready` high from edge m. The next request can be accepted at edge m+1.
- Peak throughput is one result per FRAC_W+3 cycles.
- `out_data` and `out_tag` change only at the DONE entry edge or on reset.
- Everything is registered; `in_ready` and `out_valid` decode from state only and have no combinational input-to-output path.

## Structure
- Shared package `recip_pkg`:
  - state encodings `RS_IDLE`/`RS_CALC`/`RS_DONE` (2 bits);
  - function `recip_cnt_w(FRAC_W) = $clog2(FRAC_W+1)`, used for the counter width;
  - reference function `recip_ref(a, FRAC_W)` for benches.
- One sub-module, `recip_div_step`: combinational single restoring step (inputs r, bit, d; outputs r_next, q_bit), parametrised by IN_W.
- Top: FSM, counter, r/q/d/tag registers, output registers.

## Test plan
- IN_W=4, FRAC_W=8, sweep a=0..15 with `out_ready`=1 → outputs FF,80,55,40,33,2A,24,20,1C,19,17,15,13,12,11,10; each `out_valid` rises exactly 9 cycles after acceptance.
- a=5, tag=2; `out_ready` held 0 for 6 cycles → `out_data`=0x2A and `out_tag`=2 stable throughout. `in_valid` pulsed with a=3 during DONE is not captured. After release the next result matches only the later accepted request.
- IN_W=8, FRAC_W=12: a=0 → 0xFFF; a=2 → 0x555; a=255 → 0x010. Latency is 13 cycles.
- `rst` asserted at CALC step 4 → next cycle `in_ready`=1, `busy`=0, `out_valid`=0, `out_data`=0. A fresh a=1 request then returns 0x80 with normal latency.
- Back-to-back requests with `in_valid` held high and `out_ready`=1 → results arrive every 11 cycles (FRAC_W=8). No request is duplicated or dropped.
- Random a and tag values with random `out_ready` → every result equals `recip_ref(a)` and carries its matching tag.
